conv_kernel_acc: RTL and testbench

Parametrised, pipelined KxK convolution kernel. It computes all K*K elementwise ifmap×filter products in parallel, reduces them through an adder tree, and accumulates the window sums over a run-time number of input channels. It is the next generation of the fixed 3x3 unsigned PE kernel and sits between the ifmap/filter line buffers and the output psum writeback. It adds signed mode, channel accumulation and valid/ready flow control.

---
 rtl/conv_kernel_acc.sv | 164 ++++++++++++++++
 tb/tb_conv_kernel_acc.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_kernel_acc.sv
// conv_kernel_acc
//   Pipelined KxK convolution kernel with channel accumulation.
//   Stage 0 captures an accepted window. S1 forms the K*K lane products,
//   S2 reduces them through an adder tree, and S3 accumulates the window
//   sums over cfg_nch channels. It then presents one result per output.
//   A single global stall, taken while a result waits to be consumed,
//   freezes every register in the pipeline.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     window valid
//   in_ready     window accepted this cycle (= !stall, combinational)
//   ifmap        K*K lanes of DATA_W, lane 0 in the MSBs
//   filter       K*K weights, same packing as ifmap
//   signed_mode  1 = two's-complement operands, sampled with the window
//   cfg_nch      channels per output (0 behaves as 1), latched at the
//                first channel of each output
//   out_valid    out_psum holds a completed result
//   out_ready    downstream consumes the result
//   out_psum     accumulated result, ACC_W bits, wraps modulo 2^ACC_W
module conv_kernel_acc #(
  parameter int K      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CH_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [K*K*DATA_W-1:0]   ifmap,
  input  logic [K*K*DATA_W-1:0]   filter,
  input  logic                    signed_mode,
  input  logic [CH_W-1:0]         cfg_nch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_psum
);

  localparam int N  = K * K;
  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + $clog2(N);

  logic stall;

  // stage 0: captured window
  logic                  v0;
  logic                  mode0;
  logic [N*DATA_W-1:0]   ifmap_q;
  logic [N*DATA_W-1:0]   filter_q;

  // S1: products
  logic                  v1;
  logic                  mode1;
  logic [PW-1:0]         prod_q [N];
  logic [PW-1:0]         prod_d [N];
  logic [PW-1:0]         a_x    [N];
  logic [PW-1:0]         b_x    [N];

  // S2: reduced sum
  logic                  v2;
  logic                  mode2;
  logic [SW-1:0]         sum_q;
  logic [SW-1:0]         sum_d;

  // S3: accumulation
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_d;
  logic [ACC_W-1:0]      sum_ext;
  logic [CH_W-1:0]       ch_cnt;
  logic [CH_W-1:0]       nch_q;
  logic [CH_W-1:0]       nch_eff;
  logic [CH_W-1:0]       nch_use;
  logic                  first_ch;
  logic                  last_ch;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Operands are extended to the full product width. The low PW bits of
  // the product are then exact for both signed and unsigned operands.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_x[i] = {{DATA_W{mode0 & ifmap_q[(N-1-i)*DATA_W + DATA_W-1]}},
                ifmap_q[(N-1-i)*DATA_W +: DATA_W]};
      b_x[i] = {{DATA_W{mode0 & filter_q[(N-1-i)*DATA_W + DATA_W-1]}},
                filter_q[(N-1-i)*DATA_W +: DATA_W]};
      prod_d[i] = a_x[i] * b_x[i];
    end
  end

  // The SW-bit sum cannot overflow, so modular addition gives the exact value.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) begin
      sum_d = sum_d + {{(SW-PW){mode1 & prod_q[i][PW-1]}}, prod_q[i]};
    end
  end

  always_comb begin
    sum_ext  = {{(ACC_W-SW){mode2 & sum_q[SW-1]}}, sum_q};
    nch_eff  = (cfg_nch == '0) ? CH_W'(1) : cfg_nch;
    first_ch = (ch_cnt == '0);
    // The first channel compares against the count it is latching.
    nch_use  = first_ch ? nch_eff : nch_q;
    last_ch  = (ch_cnt == nch_use - CH_W'(1));
    acc_d    = first_ch ? sum_ext : acc + sum_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0        <= 1'b0;
      mode0     <= 1'b0;
      ifmap_q   <= '0;
      filter_q  <= '0;
      v1        <= 1'b0;
      mode1     <= 1'b0;
      for (int i = 0; i < N; i++) prod_q[i] <= '0;
      v2        <= 1'b0;
      mode2     <= 1'b0;
      sum_q     <= '0;
      acc       <= '0;
      ch_cnt    <= '0;
      nch_q     <= CH_W'(1);
      out_valid <= 1'b0;
      out_psum  <= '0;
    end else if (!stall) begin
      // in_ready is 1 here, so in_valid alone means acceptance
      v0 <= in_valid;
      if (in_valid) begin
        ifmap_q  <= ifmap;
        filter_q <= filter;
        mode0    <= signed_mode;
      end

      v1 <= v0;
      if (v0) begin
        for (int i = 0; i < N; i++) prod_q[i] <= prod_d[i];
        mode1 <= mode0;
      end

      v2 <= v1;
      if (v1) begin
        sum_q <= sum_d;
        mode2 <= mode1;
      end

      // Without a stall, any pending result is being consumed now.
      // out_valid therefore follows only a completion in this cycle.
      out_valid <= v2 && last_ch;
      if (v2) begin
        acc <= acc_d;
        if (first_ch) nch_q <= nch_eff;
        if (last_ch) begin
          out_psum <= acc_d;
          ch_cnt   <= '0;
        end else begin
          ch_cnt <= ch_cnt + CH_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_kernel_acc.sv
module tb_conv_kernel_acc;
  localparam int K  = 3;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int CW = 8;
  localparam int N  = K * K;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   ifmap;
  logic [N*DW-1:0]   filter;
  logic              signed_mode;
  logic [CW-1:0]     cfg_nch;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_psum;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] seen  [$];
  int            m_cnt = 0;
  int            m_nch = 1;
  longint        m_acc = 0;
  logic          was_stall = 1'b0;
  logic [AW-1:0] held;
  bit            rand_ready = 1'b0;
  int            lat;

  always #5 clk = ~clk;

  conv_kernel_acc #(.K(K), .DATA_W(DW), .ACC_W(AW), .CH_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ifmap(ifmap), .filter(filter), .signed_mode(signed_mode),
    .cfg_nch(cfg_nch), .out_valid(out_valid), .out_ready(out_ready),
    .out_psum(out_psum)
  );

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // dot product of one window, straight from the lane definition
  function automatic longint wsum(logic [N*DW-1:0] a, logic [N*DW-1:0] b, logic m);
    longint s;
    longint x;
    longint y;
    logic [DW-1:0] ab;
    logic [DW-1:0] bb;
    s = 0;
    for (int i = 0; i < N; i++) begin
      ab = a[(N-1-i)*DW +: DW];
      bb = b[(N-1-i)*DW +: DW];
      x  = m ? longint'($signed(ab)) : longint'(ab);
      y  = m ? longint'($signed(bb)) : longint'(bb);
      s += x * y;
    end
    return s;
  endfunction

  function automatic void model_accept();
    longint s;
    s = wsum(ifmap, filter, signed_mode);
    if (m_cnt == 0) begin
      m_nch = (cfg_nch == 0) ? 1 : int'(cfg_nch);
      m_acc = s;
    end else begin
      m_acc += s;
    end
    m_cnt++;
    if (m_cnt == m_nch) begin
      exp_q.push_back(AW'(m_acc));
      m_cnt = 0;
    end
  endfunction

  function automatic logic [N*DW-1:0] fill(logic [DW-1:0] v);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  // lane 0 carries v, all other lanes zero
  function automatic logic [N*DW-1:0] one(int v);
    logic [N*DW-1:0] r;
    r = '0;
    r[N*DW-1 -: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [N*DW-1:0] rnd_win();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0: r[i*DW +: DW] = 8'h00;
        1: r[i*DW +: DW] = 8'hFF;
        2: r[i*DW +: DW] = 8'h80;
        3: r[i*DW +: DW] = 8'h7F;
        default: r[i*DW +: DW] = DW'($urandom_range(0, 255));
      endcase
    end
    return r;
  endfunction

  // The compare process runs on the falling edge, so inputs are stable.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_cnt     = 0;
      was_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (was_stall) begin
        chk("stall_valid_hold", out_valid, 1);
        chk("stall_psum_hold", out_psum, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", out_valid, 0);
        end else begin
          chk("psum", out_psum, exp_q.pop_front());
          seen.push_back(out_psum);
        end
      end
      was_stall = out_valid && !out_ready;
      held      = out_psum;
      if (in_valid && in_ready) model_accept();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, input logic m);
    int t;
    t = 0;
    in_valid = 1'b1; ifmap = a; filter = b; signed_mode = m;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; ifmap = rnd_win(); filter = rnd_win();
    signed_mode = 1'($urandom_range(0, 1));
  endtask

  // Counts falling edges until out_valid. A result completing three
  // edges after acceptance is seen on the 4th falling edge.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", (t < 100) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_psum", out_psum, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    in_valid = 1'b0; ifmap = '0; filter = '0; signed_mode = 1'b0;
    cfg_nch = 8'd1; out_ready = 1'b1;
    do_reset(3);

    // single unsigned window, latency and one-cycle pulse
    send(fill(8'd1), fill(8'd2), 1'b0);
    wait_out(lat);
    chk("t1_latency", lat, 4);
    chk("t1_psum", out_psum, 18);
    @(negedge clk);
    chk("t1_single_pulse", out_valid, 0);
    drain();

    // signed vs unsigned interpretation of the same bits
    send(fill(8'hFF), fill(8'h7F), 1'b1);
    wait_out(lat);
    chk("t2_signed", out_psum, 32'hFFFFFB89);
    drain();
    send(fill(8'hFF), fill(8'h7F), 1'b0);
    wait_out(lat);
    chk("t2_unsigned", out_psum, 32'h00047289);
    drain();

    // four channels back to back
    cfg_nch = 8'd4;
    for (int k = 0; k < 4; k++) send(fill(8'hFF), fill(8'hFF), 1'b0);
    wait_out(lat);
    chk("t3_latency", lat, 4);
    chk("t3_psum", out_psum, 2340900);
    drain();

    // backpressure with six single-channel results
    cfg_nch = 8'd1;
    out_ready = 1'b0;
    seen.delete();
    fork
      for (int k = 1; k <= 6; k++) send(one(k), one(1), 1'b0);
      begin
        wait_out(lat);
        chk("t4_in_ready_low", in_ready, 0);
        repeat (5) begin
          chk("t4_psum_held", out_psum, 1);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_count", seen.size(), 6);
    for (int k = 0; k < 6 && k < seen.size(); k++) chk("t4_order", seen[k], k + 1);

    // reset discards a partial accumulation
    cfg_nch = 8'd4;
    send(one(3), one(1), 1'b0);
    send(one(5), one(1), 1'b0);
    do_reset(1);
    for (int k = 0; k < 4; k++) send(one(10), one(1), 1'b0);
    wait_out(lat);
    chk("t5_psum", out_psum, 40);
    drain();

    // zero channel count behaves as one
    cfg_nch = 8'd0;
    send(one(7), one(1), 1'b0);
    wait_out(lat);
    chk("t6_nch0", out_psum, 7);
    drain();

    // count change after the first channel does not affect the output in flight
    cfg_nch = 8'd2;
    send(one(3), one(1), 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    cfg_nch = 8'd3;
    send(one(4), one(1), 1'b0);
    wait_out(lat);
    chk("t6_latched_nch", out_psum, 7);
    drain();

    // randomized traffic with random backpressure
    for (int p = 0; p < 5; p++) begin
      case (p)
        0: cfg_nch = 8'd1;
        1: cfg_nch = 8'd2;
        2: cfg_nch = 8'd4;
        3: cfg_nch = 8'd5;
        default: cfg_nch = 8'd0;
      endcase
      rand_ready = 1'b1;
      for (int w = 0; w < 40; w++) begin
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk);
          #1;
        end
        send(rnd_win(), rnd_win(), 1'($urandom_range(0, 1)));
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain();
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
